// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: arbitrates N_REQ byte requesters onto one UART transmitter
// through a TX_Ready / TX_en handshake. Each handshake phase has a timeout.
module uart_tx_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_lock,
    output logic [N_REQ-1:0]   ack,
    input  logic               tx_ready,
    output logic               tx_en,
    output logic [7:0]         tx_data,
    output logic               busy,
    output logic               timeout_err
);
    // state | meaning
    // IDLE  | waiting for tx_ready=1 and any req, then grants one byte
    // SEND  | tx_en high, waiting for the transmitter to drop tx_ready
    // DRAIN | byte accepted, waiting for tx_ready to return high

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] LAST_RST  = GW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ABORT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [GW-1:0]    r_grant;
    logic [GW-1:0]    r_last_grant;
    logic             r_lock_hold;
    logic [CW-1:0]    r_cnt;
    logic             r_tx_en;
    logic [7:0]       r_tx_data;
    logic [N_REQ-1:0] r_ack;
    logic             r_busy;
    logic             r_err;

    logic             w_rr_found;
    logic [GW-1:0]    w_rr_idx;
    logic             w_lock_win;
    logic [GW-1:0]    w_sel;
    logic             w_do_grant;
    logic             w_phase_to;
    logic             w_done;
    logic             w_abort;

    logic [GW-1:0]    w_grant_nxt;
    logic [GW-1:0]    w_last_nxt;
    logic             w_lock_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_tx_en_nxt;
    logic [7:0]       w_tx_data_nxt;
    logic [N_REQ-1:0] w_ack_nxt;
    logic             w_busy_nxt;
    logic             w_err_nxt;

    // Round-robin search starting one past the last completed grant.
    always_comb begin : arb
        int            j;
        logic [GW-1:0] jj;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        j          = 0;
        jj         = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j  = (int'(r_last_grant) + k) % N_REQ;
            jj = GW'(j);
            if (!w_rr_found && req[jj]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = jj;
            end
        end
    end

    // Packet mode: the previous owner keeps the grant while it still asks for it.
    assign w_lock_win = r_lock_hold & req_lock[r_last_grant] & req[r_last_grant];
    assign w_sel      = w_lock_win ? r_last_grant : w_rr_idx;
    assign w_do_grant = (r_state == S_IDLE) & tx_ready & (|req);
    assign w_phase_to = (r_cnt == CNT_ABORT);

    always_ff @(posedge clk) begin
        if (reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_do_grant) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_ready) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_phase_to) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end
            end
            S_DRAIN: begin
                if (tx_ready) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end else if (w_phase_to) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // An aborted byte is simply dropped: it was acked at capture time.
    always_comb begin
        w_tx_en_nxt   = 1'b0;
        w_tx_data_nxt = r_tx_data;
        w_ack_nxt     = '0;
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_err_nxt     = r_err | w_abort;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last_grant;
        w_lock_nxt    = r_lock_hold;
        w_cnt_nxt     = r_cnt;
        if (w_do_grant) begin
            w_tx_en_nxt      = 1'b1;
            w_tx_data_nxt    = req_data[{w_sel, 3'b000} +: 8];
            w_ack_nxt[w_sel] = 1'b1;
            w_grant_nxt      = w_sel;
            w_lock_nxt       = req_lock[w_sel];
        end
        if ((r_state == S_SEND) && (w_state_nxt == S_SEND)) begin
            w_tx_en_nxt = 1'b1;
        end
        if (w_done || w_abort) begin
            w_last_nxt = r_grant;
        end
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if ((r_state != S_IDLE) && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            r_grant      <= '0;
            r_last_grant <= LAST_RST;
            r_lock_hold  <= 1'b0;
            r_cnt        <= '0;
            r_tx_en      <= 1'b0;
            r_tx_data    <= 8'h00;
            r_ack        <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_lock_hold  <= w_lock_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tx_en      <= w_tx_en_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_ack        <= w_ack_nxt;
            r_busy       <= w_busy_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign ack         = r_ack;
    assign tx_en       = r_tx_en;
    assign tx_data     = r_tx_data;
    assign busy        = r_busy;
    assign timeout_err = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: handshake, round-robin order, lock,
// timeout abort, tx_ready gating and reset during DRAIN.
module tb_uart_tx_scheduler;
    logic        clk = 1'b0;
    logic        reset_b;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  ack;
    logic        tx_ready;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .N_REQ  (4),
        .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .req        (req),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .ack        (ack),
        .tx_ready   (tx_ready),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete byte: wait for grant, hold tx_ready 3 cycles, low 6, then high.
    task automatic send_byte(input string tag, input int idx, input logic [7:0] dat,
                             input logic [3:0] req_after, input logic [3:0] lock_after);
        int         n;
        logic [3:0] stray;
        n = 0;
        while (tx_en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_en"},   32'(tx_en),   32'd1);
        check({tag, "_ack"},  32'(ack),     32'(1 << idx));
        check({tag, "_data"}, 32'(tx_data), 32'(dat));
        req      = req_after;
        req_lock = lock_after;
        stray    = '0;
        repeat (3) begin
            step();
            stray |= ack;
        end
        tx_ready = 1'b0;
        repeat (6) begin
            step();
            stray |= ack;
        end
        check({tag, "_drain_en"},   32'(tx_en),   32'd0);
        check({tag, "_drain_busy"}, 32'(busy),    32'd1);
        check({tag, "_drain_data"}, 32'(tx_data), 32'(dat));
        tx_ready = 1'b1;
        n = 0;
        do begin
            step();
            stray |= ack;
            n++;
        end while (busy !== 1'b0 && n < 20);
        check({tag, "_idle"},  32'(busy),  32'd0);
        check({tag, "_stray"}, 32'(stray), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] stray;
        reset_b  = 1'b1;
        req      = '0;
        req_data = '0;
        req_lock = '0;
        tx_ready = 1'b1;
        step();
        step();
        check("rst_en",   32'(tx_en),       32'd0);
        check("rst_data", 32'(tx_data),     32'd0);
        check("rst_ack",  32'(ack),         32'd0);
        check("rst_busy", 32'(busy),        32'd0);
        check("rst_err",  32'(timeout_err), 32'd0);
        reset_b = 1'b0;

        // Single byte handshake; data change after ack must not leak through.
        req      = 4'b0001;
        req_data = 32'h0000_00A5;
        step();
        check("a_en",   32'(tx_en),   32'd1);
        check("a_data", 32'(tx_data), 32'hA5);
        check("a_ack",  32'(ack),     32'h1);
        check("a_busy", 32'(busy),    32'd1);
        req      = 4'b0000;
        req_data = 32'h0000_00FF;
        step();
        check("a_ack_once", 32'(ack),     32'd0);
        check("a_send_en",  32'(tx_en),   32'd1);
        check("a_send_dat", 32'(tx_data), 32'hA5);
        tx_ready = 1'b0;
        step();
        check("a_drain_en",  32'(tx_en),   32'd0);
        check("a_drain_bsy", 32'(busy),    32'd1);
        check("a_drain_dat", 32'(tx_data), 32'hA5);
        tx_ready = 1'b1;
        step();
        check("a_done_busy", 32'(busy), 32'd0);

        // Round robin from reset with all four requesting.
        reset_b = 1'b1;
        step();
        reset_b  = 1'b0;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req      = 4'b1111;
        send_byte("rr0", 0, 8'h11, 4'b1111, 4'b0000);
        send_byte("rr1", 1, 8'h22, 4'b1111, 4'b0000);
        send_byte("rr2", 2, 8'h33, 4'b1111, 4'b0000);
        send_byte("rr3", 3, 8'h44, 4'b1111, 4'b0000);
        send_byte("rr4", 0, 8'h11, 4'b0000, 4'b0000);

        // Lock: 2 keeps the grant over 1, then 1 wins once lock drops.
        req      = 4'b0100;
        req_lock = 4'b0100;
        send_byte("lk0", 2, 8'h33, 4'b0110, 4'b0100);
        send_byte("lk1", 2, 8'h33, 4'b0110, 4'b0000);
        send_byte("lk2", 1, 8'h22, 4'b0000, 4'b0000);

        // No grant while tx_ready is low.
        tx_ready = 1'b0;
        req      = 4'b0001;
        stray    = '0;
        repeat (3) begin
            step();
            stray |= ack;
        end
        check("nr_ack",  32'(stray), 32'd0);
        check("nr_busy", 32'(busy),  32'd0);
        tx_ready = 1'b1;
        step();
        check("nr_grant_ack", 32'(ack),     32'h1);
        check("nr_grant_dat", 32'(tx_data), 32'h11);

        // tx_ready stuck high: abort after 16 cycles of tx_en.
        req   = 4'b0000;
        stray = '0;
        repeat (15) begin
            step();
            stray |= ack;
        end
        check("to_en_hold", 32'(tx_en),       32'd1);
        check("to_err_pre", 32'(timeout_err), 32'd0);
        step();
        stray |= ack;
        check("to_en_drop", 32'(tx_en),       32'd0);
        check("to_err",     32'(timeout_err), 32'd1);
        check("to_busy",    32'(busy),        32'd0);
        repeat (3) begin
            step();
            stray |= ack;
        end
        check("to_no_reack", 32'(stray),       32'd0);
        check("to_sticky",   32'(timeout_err), 32'd1);

        // Reset while in DRAIN, then requester 0 must win.
        req = 4'b0100;
        step();
        check("rd_ack",  32'(ack),     32'h4);
        check("rd_data", 32'(tx_data), 32'h33);
        req      = 4'b0000;
        tx_ready = 1'b0;
        step();
        check("rd_drain_busy", 32'(busy),  32'd1);
        check("rd_drain_en",   32'(tx_en), 32'd0);
        reset_b = 1'b1;
        step();
        check("rd_rst_en",   32'(tx_en),       32'd0);
        check("rd_rst_data", 32'(tx_data),     32'd0);
        check("rd_rst_ack",  32'(ack),         32'd0);
        check("rd_rst_busy", 32'(busy),        32'd0);
        check("rd_rst_err",  32'(timeout_err), 32'd0);
        reset_b  = 1'b0;
        req      = 4'b0101;
        tx_ready = 1'b1;
        step();
        check("rd_first_ack",  32'(ack),     32'h1);
        check("rd_first_data", 32'(tx_data), 32'h11);
        req = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
